// File: rtl/adpll_seq.sv
// adpll_seq: bus master that runs the ADPLL channel-acquisition sequence.
// It disables the ADPLL, pulses soft reset, programs FCW and mode, enables the
// loop, polls lock with a timeout, and then checks saturation.
//
// Optional build macro: ADPLL_SEQ_LOCK_FILT_EN. When it is defined, LOCK_CNT
// consecutive lock=1 reads are needed before the saturation check.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, abort      one-cycle host requests
//   fcw_in, mode_in   channel word and ADPLL mode, captured when start is accepted
//   busy, done        sequence in progress, and the one-cycle end pulse
//   status            0 ok, 1 timeout, 2 saturated, 3 aborted
//   locked            set by an ok completion
//   m_valid, m_address, m_wdata, m_wstrb, m_rdata, m_ready
//                     register bus master (m_wstrb=1 is a write)

`ifndef FCWW
`define FCWW 26
`endif
`ifndef ADPLL_ADDR_W
`define ADPLL_ADDR_W 8
`endif
`ifndef ADPLL_DATA_W
`define ADPLL_DATA_W 32
`endif

module adpll_seq #(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [`FCWW-1:0]          fcw_in,
    input  logic [1:0]                mode_in,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                status,
    output logic                      locked,
    output logic                      m_valid,
    output logic [`ADPLL_ADDR_W-1:0]  m_address,
    output logic [`ADPLL_DATA_W-1:0]  m_wdata,
    output logic                      m_wstrb,
    input  logic [1:0]                m_rdata,
    input  logic                      m_ready
);

    localparam int unsigned FCW_W  = `FCWW;
    localparam int unsigned ADDR_W = `ADPLL_ADDR_W;
    localparam int unsigned DATA_W = `ADPLL_DATA_W;

    // ADPLL register map
    localparam logic [ADDR_W-1:0] A_EN       = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_SOFT_RST = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_FCW      = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] A_MODE     = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0] A_LOCK     = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] A_SAT      = ADDR_W'(8'h14);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_SAT     = 2'd2;
    localparam logic [1:0] ST_ABORT   = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_DIS,
        S_W_RST1,
        S_W_RST0,
        S_W_FCW,
        S_W_MODE,
        S_W_EN,
        S_POLL,
        S_R_SAT,
        S_W_OFF,
        S_FIN
    } state_t;

    state_t              state, state_d;
    logic [FCW_W-1:0]    fcw_q, fcw_d;
    logic [1:0]          mode_q, mode_d;
    logic                abort_q, abort_d;
    logic [CNT_W-1:0]    tmo_cnt, tmo_d;
    logic                busy_d, done_d, locked_d;
    logic [1:0]          status_d;
    logic                valid_d, wstrb_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;

    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic                req_wr;

    logic                abort_hit_c;
    logic                tmo_hit_c;
    logic                lock_ok_c;

    // Abort counts from the cycle it arrives as well as once latched.
    assign abort_hit_c = abort_q | abort;
    assign tmo_hit_c   = (tmo_cnt >= CNT_W'(TIMEOUT_CYC - 1));

`ifdef ADPLL_SEQ_LOCK_FILT_EN
    localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);

    logic [RUN_W-1:0]    lock_run, lock_run_d;

    // This read is a lock and completes the required run of consecutive locks.
    assign lock_ok_c = m_rdata[0] && ((32'(lock_run) + 32'd1) >= LOCK_CNT);
`else
    assign lock_ok_c = m_rdata[0];
`endif

    // rdata[1] carries nothing; LOCK_CNT only matters with lock filtering.
    logic unused_ok;
    assign unused_ok = ^{m_rdata[1], LOCK_CNT};

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            fcw_q     <= '0;
            mode_q    <= '0;
            abort_q   <= 1'b0;
            tmo_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            status    <= '0;
            locked    <= 1'b0;
            m_valid   <= 1'b0;
            m_address <= '0;
            m_wdata   <= '0;
            m_wstrb   <= 1'b0;
`ifdef ADPLL_SEQ_LOCK_FILT_EN
            lock_run  <= '0;
`endif
        end else begin
            state     <= state_d;
            fcw_q     <= fcw_d;
            mode_q    <= mode_d;
            abort_q   <= abort_d;
            tmo_cnt   <= tmo_d;
            busy      <= busy_d;
            done      <= done_d;
            status    <= status_d;
            locked    <= locked_d;
            m_valid   <= valid_d;
            m_address <= addr_d;
            m_wdata   <= wdata_d;
            m_wstrb   <= wstrb_d;
`ifdef ADPLL_SEQ_LOCK_FILT_EN
            lock_run  <= lock_run_d;
`endif
        end
    end

    // Next state, bus request and status decisions
    always_comb begin
        state_d   = state;
        fcw_d     = fcw_q;
        mode_d    = mode_q;
        abort_d   = abort_q;
        tmo_d     = tmo_cnt;
        busy_d    = busy;
        done_d    = 1'b0;
        status_d  = status;
        locked_d  = locked;
        valid_d   = m_valid;
        addr_d    = m_address;
        wdata_d   = m_wdata;
        wstrb_d   = m_wstrb;
`ifdef ADPLL_SEQ_LOCK_FILT_EN
        lock_run_d = lock_run;
`endif
        req_addr  = '0;
        req_wdata = '0;
        req_wr    = 1'b0;

        // Transaction each bus state issues
        case (state)
            S_W_DIS, S_W_OFF: begin req_addr = A_EN;       req_wr = 1'b1; end
            S_W_RST1: begin req_addr = A_SOFT_RST; req_wdata = DATA_W'(1); req_wr = 1'b1; end
            S_W_RST0: begin req_addr = A_SOFT_RST; req_wr = 1'b1; end
            S_W_FCW:  begin req_addr = A_FCW;  req_wdata = DATA_W'(fcw_q);  req_wr = 1'b1; end
            S_W_MODE: begin req_addr = A_MODE; req_wdata = DATA_W'(mode_q); req_wr = 1'b1; end
            S_W_EN:   begin req_addr = A_EN;   req_wdata = DATA_W'(1);      req_wr = 1'b1; end
            S_POLL:   req_addr = A_LOCK;
            S_R_SAT:  req_addr = A_SAT;
            default:  ;
        endcase

        if (state != S_IDLE && abort)
            abort_d = 1'b1;

        // Timeout counter runs every cycle in POLL and saturates
        if (state == S_POLL && tmo_cnt != '1)
            tmo_d = tmo_cnt + CNT_W'(1);

        case (state)
            S_IDLE: begin
                abort_d = 1'b0;
                if (start && !abort) begin
                    fcw_d    = fcw_in;
                    mode_d   = mode_in;
                    status_d = ST_OK;
                    locked_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_W_DIS;
                end
            end

            // Final disable runs to completion regardless of abort.
            S_W_OFF: begin
                if (!m_valid) begin
                    valid_d = 1'b1;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wr;
                end else if (m_ready) begin
                    valid_d = 1'b0;
                    state_d = S_FIN;
                end
            end

            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                if (!m_valid) begin
                    // Between transactions: nothing in flight, so divert here.
                    if (abort_hit_c) begin
                        status_d = ST_ABORT;
                        state_d  = S_W_OFF;
                    end else if (state == S_POLL && tmo_hit_c) begin
                        status_d = ST_TIMEOUT;
                        state_d  = S_W_OFF;
                    end else begin
                        valid_d = 1'b1;
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        wstrb_d = req_wr;
                    end
                end else if (m_ready) begin
                    valid_d = 1'b0;
                    if (abort_hit_c) begin
                        status_d = ST_ABORT;
                        state_d  = S_W_OFF;
                    end else begin
                        case (state)
                            S_W_DIS:  state_d = S_W_RST1;
                            S_W_RST1: state_d = S_W_RST0;
                            S_W_RST0: state_d = S_W_FCW;
                            S_W_FCW:  state_d = S_W_MODE;
                            S_W_MODE: state_d = S_W_EN;
                            S_W_EN: begin
                                state_d = S_POLL;
                                tmo_d   = '0;
`ifdef ADPLL_SEQ_LOCK_FILT_EN
                                lock_run_d = '0;
`endif
                            end
                            S_POLL: begin
`ifdef ADPLL_SEQ_LOCK_FILT_EN
                                lock_run_d = m_rdata[0] ? lock_run + RUN_W'(1) : '0;
`endif
                                // Timeout wins over a lock landing on the limit
                                if (tmo_hit_c) begin
                                    status_d = ST_TIMEOUT;
                                    state_d  = S_W_OFF;
                                end else if (lock_ok_c) begin
                                    state_d = S_R_SAT;
                                end
                            end
                            S_R_SAT: begin
                                if (m_rdata[0]) begin
                                    status_d = ST_SAT;
                                    state_d  = S_W_OFF;
                                end else begin
                                    status_d = ST_OK;
                                    locked_d = 1'b1;
                                    state_d  = S_FIN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_adpll_seq.sv
// tb_adpll_seq: self-checking bench for adpll_seq. A reactive register slave
// logs every completed transaction; each test compares that log and the
// status outputs with a sequence-level model of the acquisition flow.

`ifndef FCWW
`define FCWW 26
`endif
`ifndef ADPLL_ADDR_W
`define ADPLL_ADDR_W 8
`endif
`ifndef ADPLL_DATA_W
`define ADPLL_DATA_W 32
`endif

module tb_adpll_seq;

    localparam int unsigned TMO   = 64;
    localparam int unsigned LOCKN = 4;
    localparam int unsigned FW    = `FCWW;
    localparam int unsigned AW    = `ADPLL_ADDR_W;
    localparam int unsigned DW    = `ADPLL_DATA_W;
`ifdef ADPLL_SEQ_LOCK_FILT_EN
    localparam int unsigned LOCK_TGT = LOCKN;
`else
    localparam int unsigned LOCK_TGT = 1;
`endif

    localparam logic [AW-1:0] A_EN   = AW'(8'h00);
    localparam logic [AW-1:0] A_RST  = AW'(8'h04);
    localparam logic [AW-1:0] A_FCW  = AW'(8'h08);
    localparam logic [AW-1:0] A_MODE = AW'(8'h0C);
    localparam logic [AW-1:0] A_LOCK = AW'(8'h10);
    localparam logic [AW-1:0] A_SAT  = AW'(8'h14);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          wr;
    } txn_t;

    logic          clk, rst, start, abort;
    logic [FW-1:0] fcw_in;
    logic [1:0]    mode_in;
    logic          busy, done, locked;
    logic [1:0]    status;
    logic          m_valid, m_wstrb, m_ready;
    logic [AW-1:0] m_address;
    logic [DW-1:0] m_wdata;
    logic [1:0]    m_rdata;

    adpll_seq #(.TIMEOUT_CYC(TMO), .LOCK_CNT(LOCKN), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .fcw_in(fcw_in), .mode_in(mode_in),
        .busy(busy), .done(done), .status(status), .locked(locked),
        .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    txn_t log_q[$];
    int   stamp_q[$];
    txn_t exp_q[$];
    bit   lock_pat[$];
    bit   lock_dflt;
    bit   sat_val;
    int   rdy_dly;
    int   lock_idx;
    int   proto_viol;
    int   done_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Register slave: ready after rdy_dly waiting cycles, answers LOCK/SAT
    // reads from the configured pattern, and counts held-field or gap errors.
    initial begin : slave
        bit   waiting;
        int   wcnt;
        txn_t held, cur;
        bit   b;
        m_ready = 1'b0;
        m_rdata = 2'b00;
        waiting = 1'b0;
        wcnt    = 0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            cur.addr = m_address;
            cur.data = m_wdata;
            cur.wr   = m_wstrb;
            if (rst) begin
                m_ready = 1'b0;
                waiting = 1'b0;
            end else if (m_ready) begin
                m_ready = 1'b0;
                waiting = 1'b0;
                if (m_valid) proto_viol++;
            end else if (m_valid) begin
                if (!waiting) begin
                    waiting = 1'b1;
                    wcnt    = 0;
                    held    = cur;
                end else if (held !== cur) begin
                    proto_viol++;
                end
                if (wcnt >= rdy_dly) begin
                    m_ready = 1'b1;
                    b = 1'b0;
                    if (!m_wstrb && m_address == A_LOCK) begin
                        b = (lock_idx < lock_pat.size()) ? lock_pat[lock_idx] : lock_dflt;
                        lock_idx++;
                    end else if (!m_wstrb && m_address == A_SAT) begin
                        b = sat_val;
                    end
                    m_rdata = {1'($urandom_range(0, 1)), b};
                    log_q.push_back(cur);
                    stamp_q.push_back(cyc);
                end else begin
                    wcnt++;
                end
            end else begin
                waiting = 1'b0;
            end
        end
    end

    function automatic txn_t wr_t(input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.addr = a; t.data = d; t.wr = 1'b1;
        return t;
    endfunction

    function automatic txn_t rd_t(input logic [AW-1:0] a);
        txn_t t;
        t.addr = a; t.data = '0; t.wr = 1'b0;
        return t;
    endfunction

    // Number of LOCK reads until LOCK_TGT consecutive ones have been seen
    function automatic int lock_reads_needed();
        int run = 0;
        for (int i = 0; i < 256; i++) begin
            bit b;
            b = (i < lock_pat.size()) ? lock_pat[i] : lock_dflt;
            run = b ? run + 1 : 0;
            if (run >= int'(LOCK_TGT)) return i + 1;
        end
        return -1;
    endfunction

    task automatic expect_prefix(input logic [FW-1:0] f, input logic [1:0] m);
        exp_q.delete();
        exp_q.push_back(wr_t(A_EN, DW'(0)));
        exp_q.push_back(wr_t(A_RST, DW'(1)));
        exp_q.push_back(wr_t(A_RST, DW'(0)));
        exp_q.push_back(wr_t(A_FCW, DW'(f)));
        exp_q.push_back(wr_t(A_MODE, DW'(m)));
        exp_q.push_back(wr_t(A_EN, DW'(1)));
    endtask

    // Full expected log for a run that reaches the saturation read
    task automatic expect_full(input logic [FW-1:0] f, input logic [1:0] m);
        int n;
        expect_prefix(f, m);
        n = lock_reads_needed();
        for (int i = 0; i < n; i++) exp_q.push_back(rd_t(A_LOCK));
        exp_q.push_back(rd_t(A_SAT));
        if (sat_val) exp_q.push_back(wr_t(A_EN, DW'(0)));
    endtask

    function automatic int log_diff();
        int d = 0;
        int n = (log_q.size() > exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (i >= log_q.size() || i >= exp_q.size() || log_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic setup(input bit dflt, input bit sat, input int dly);
        log_q.delete();
        stamp_q.delete();
        lock_dflt  = dflt;
        sat_val    = sat;
        rdy_dly    = dly;
        lock_idx   = 0;
        proto_viol = 0;
        done_cnt   = 0;
    endtask

    task automatic pulse_start(input logic [FW-1:0] f, input logic [1:0] m);
        @(negedge clk);
        fcw_in  = f;
        mode_in = m;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, status, locked, m_valid, m_wstrb} !== 7'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0", {busy, done, status, locked, m_valid, m_wstrb});
        end
        checks++;
        if (m_address !== '0) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 0", m_address);
        end
        checks++;
        if (m_wdata !== '0) begin
            errors++;
            $display("FAIL reset_wdata: got %h expected 0", m_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ok_path();
        bit ok;
        logic [FW-1:0] f;
        f = FW'(32'h2620000);
        setup(1'b1, 1'b0, 1);
        lock_pat = '{1'b0, 1'b0, 1'b1};
        expect_full(f, 2'd2);
        pulse_start(f, 2'd2);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ok_done: done not seen within budget"); end
        checks++;
        if (status !== 2'd0 || locked !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ok_status: got st=%0d lk=%b busy=%b expected st=0 lk=1 busy=0", status, locked, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (log_diff() !== 0) begin
            errors++;
            $display("FAIL ok_log: got %0d txns (%0d differ) expected %0d", log_q.size(), log_diff(), exp_q.size());
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL ok_done_cnt: got %0d expected 1", done_cnt); end
        checks++;
        if (proto_viol !== 0) begin errors++; $display("FAIL ok_bus: got %0d violations expected 0", proto_viol); end
    endtask

    task automatic test_timeout();
        bit ok;
        int bad, span, n;
        logic [FW-1:0] f;
        f = FW'($urandom);
        setup(1'b0, 1'b0, 1);
        lock_pat.delete();
        expect_prefix(f, 2'd1);
        pulse_start(f, 2'd1);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tmo_done: done not seen within budget"); end
        checks++;
        if (status !== 2'd1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL tmo_status: got st=%0d lk=%b expected st=1 lk=0", status, locked);
        end
        n = log_q.size();
        bad = 0;
        if (n < 8) bad = 100;
        else begin
            for (int i = 0; i < 6; i++) if (log_q[i] !== exp_q[i]) bad++;
            for (int i = 6; i < n - 1; i++) if (log_q[i] !== rd_t(A_LOCK)) bad++;
            if (log_q[n-1] !== wr_t(A_EN, DW'(0))) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL tmo_log: got %0d bad entries of %0d expected 0", bad, n); end
        span = (n >= 8) ? stamp_q[n-2] - stamp_q[5] : -1;
        checks++;
        if (span > int'(TMO) + rdy_dly + 2 || span < int'(TMO) - 2 * (rdy_dly + 2)) begin
            errors++;
            $display("FAIL tmo_span: got %0d poll cycles expected about %0d", span, TMO);
        end
    endtask

    task automatic test_saturation();
        bit ok;
        logic [FW-1:0] f;
        logic [1:0] m;
        f = FW'($urandom);
        m = 2'($urandom);
        setup(1'b1, 1'b1, 0);
        lock_pat.delete();
        expect_full(f, m);
        pulse_start(f, m);
        wait_done(ok);
        checks++;
        if (!ok || status !== 2'd2 || locked !== 1'b0) begin
            errors++;
            $display("FAIL sat_status: got done=%b st=%0d lk=%b expected done=1 st=2 lk=0", ok, status, locked);
        end
        checks++;
        if (log_diff() !== 0) begin
            errors++;
            $display("FAIL sat_log: got %0d txns (%0d differ) expected %0d", log_q.size(), log_diff(), exp_q.size());
        end
    endtask

    task automatic test_abort();
        bit ok, seen;
        logic [FW-1:0] f;
        f = FW'($urandom);
        setup(1'b1, 1'b0, 5);
        lock_pat.delete();
        expect_prefix(f, 2'd3);
        exp_q = exp_q[0:3];
        exp_q.push_back(wr_t(A_EN, DW'(0)));
        pulse_start(f, 2'd3);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_valid && m_address == A_FCW) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL abort_fcw_seen: got no FCW request expected one"); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || status !== 2'd3 || locked !== 1'b0) begin
            errors++;
            $display("FAIL abort_status: got done=%b st=%0d lk=%b expected done=1 st=3 lk=0", ok, status, locked);
        end
        checks++;
        if (log_diff() !== 0) begin
            errors++;
            $display("FAIL abort_log: got %0d txns (%0d differ) expected %0d", log_q.size(), log_diff(), exp_q.size());
        end
        checks++;
        if (proto_viol !== 0) begin errors++; $display("FAIL abort_hold: got %0d violations expected 0", proto_viol); end
    endtask

    task automatic test_start_ignored();
        bit ok;
        logic [FW-1:0] f;
        logic [1:0] m;
        f = FW'($urandom);
        m = 2'($urandom);
        setup(1'b1, 1'b0, 2);
        lock_pat.delete();
        expect_full(f, m);
        @(negedge clk);
        fcw_in  = f;
        mode_in = m;
        start   = 1'b1;
        @(negedge clk);
        fcw_in  = ~f;
        mode_in = ~m;
        wait_done(ok);
        start = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (!ok || done_cnt !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_done_cnt: got done=%b count=%0d busy=%b expected 1 1 0", ok, done_cnt, busy);
        end
        checks++;
        if (log_diff() !== 0) begin
            errors++;
            $display("FAIL hold_log: got %0d txns (%0d differ) expected %0d", log_q.size(), log_diff(), exp_q.size());
        end
        setup(1'b1, 1'b0, 0);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || log_q.size() !== 0 || done_cnt !== 0) begin
            errors++;
            $display("FAIL start_abort_idle: got busy=%b txns=%0d dones=%0d expected 0 0 0", busy, log_q.size(), done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        logic [FW-1:0] f;
        logic [1:0] m;
        setup(1'b0, 1'b0, 2);
        lock_pat.delete();
        pulse_start(FW'($urandom), 2'd1);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_valid && !m_wstrb && m_address == A_LOCK) begin seen = 1'b1; break; end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (!seen || {m_valid, busy, status, done, locked} !== 6'd0) begin
            errors++;
            $display("FAIL rst_mid: got seen=%b vld/busy/st/done/lk=%b expected 1 000000", seen, {m_valid, busy, status, done, locked});
        end
        rst = 1'b0;
        @(negedge clk);
        f = FW'($urandom);
        m = 2'($urandom);
        setup(1'b1, 1'b0, 1);
        expect_full(f, m);
        pulse_start(f, m);
        wait_done(ok);
        checks++;
        if (!ok || status !== 2'd0 || locked !== 1'b1 || log_diff() !== 0) begin
            errors++;
            $display("FAIL rst_rerun: got done=%b st=%0d lk=%b diff=%0d expected 1 0 1 0", ok, status, locked, log_diff());
        end
    endtask

    task automatic test_lock_filter();
        bit ok;
        int reads;
        setup(1'b0, 1'b0, 0);
        lock_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        expect_full(FW'(32'h1234567), 2'd0);
        pulse_start(FW'(32'h1234567), 2'd0);
        wait_done(ok);
        reads = 0;
        foreach (log_q[i]) if (log_q[i] === rd_t(A_LOCK)) reads++;
        checks++;
        if (reads !== ((LOCK_TGT == 4) ? 7 : 1)) begin
            errors++;
            $display("FAIL filt_reads: got %0d lock reads expected %0d", reads, (LOCK_TGT == 4) ? 7 : 1);
        end
        checks++;
        if (!ok || status !== 2'd0 || locked !== 1'b1 || log_diff() !== 0) begin
            errors++;
            $display("FAIL filt_seq: got done=%b st=%0d lk=%b diff=%0d expected 1 0 1 0", ok, status, locked, log_diff());
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [FW-1:0] f;
        logic [1:0] m;
        bit sat;
        int pre;
        for (int it = 0; it < 8; it++) begin
            f   = FW'($urandom);
            m   = 2'($urandom);
            sat = 1'($urandom);
            setup(1'b1, sat, int'($urandom_range(0, 3)));
            lock_pat.delete();
            pre = int'($urandom_range(0, 3));
            for (int i = 0; i < pre; i++) lock_pat.push_back(1'($urandom));
            expect_full(f, m);
            pulse_start(f, m);
            wait_done(ok);
            checks++;
            if (!ok || status !== (sat ? 2'd2 : 2'd0) || locked !== !sat) begin
                errors++;
                $display("FAIL rand%0d_status: got done=%b st=%0d lk=%b expected st=%0d lk=%b", it, ok, status, locked, sat ? 2 : 0, !sat);
            end
            checks++;
            if (log_diff() !== 0 || proto_viol !== 0) begin
                errors++;
                $display("FAIL rand%0d_log: got diff=%0d viol=%0d expected 0 0", it, log_diff(), proto_viol);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        fcw_in  = '0;
        mode_in = '0;
        setup(1'b0, 1'b0, 0);
        test_reset();
        test_ok_path();
        test_timeout();
        test_saturation();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_lock_filter();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
